// File: rtl/rggen_rtl_pkg.sv
// Shared types and helpers for the register access initiator.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package rggen_rtl_pkg;

    // Initiator access sequence: wait for host, drive command, return response
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } rggen_access_state_e;

    // One strobe bit enables all eight bits of its byte lane
    function automatic logic [7:0] rggen_byte_mask(input logic strobe);
        return {8{strobe}};
    endfunction

endpackage

// File: rtl/rggen_access_timer.sv
// Counts ACCESS cycles and flags the cycle in which the timeout budget is used up.
// Latency: o_expired is combinational from the count and i_enable.
// Backpressure: none; the count saturates at its last value.
module rggen_access_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int             COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;

    // Count holds the number of ACCESS cycles already elapsed before this one
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && (count_q != LAST_COUNT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expired = i_enable && (count_q == LAST_COUNT);

endmodule

// File: rtl/rggen_register_access_initiator.sv
// Register bus initiator: one host access at a time, command broadcast, one-cycle done/error response.
// Latency: accept T0, command from T1, done one cycle after ready/decode miss; minimum 3-cycle service.
// Backpressure: o_host_ready only in IDLE; optional timeout via RGGEN_ACCESS_TIMEOUT_EN.
module rggen_register_access_initiator
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int TOTAL_REGISTERS = 1,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_host_request,
    input  logic                                  i_host_write,
    input  logic [ADDRESS_WIDTH-1:0]              i_host_address,
    input  logic [DATA_WIDTH-1:0]                 i_host_write_data,
    input  logic [DATA_WIDTH/8-1:0]               i_host_strobe,
    output logic                                  o_host_ready,
    output logic                                  o_host_done,
    output logic                                  o_host_error,
    output logic [DATA_WIDTH-1:0]                 o_host_read_data,
    output logic                                  o_command_valid,
    output logic                                  o_write,
    output logic [ADDRESS_WIDTH-1:0]              o_address,
    output logic [DATA_WIDTH-1:0]                 o_write_data,
    output logic [DATA_WIDTH-1:0]                 o_write_mask,
    input  logic [TOTAL_REGISTERS-1:0]            i_register_select,
    input  logic [TOTAL_REGISTERS-1:0]            i_register_ready,
    input  logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] i_register_read_data
);
    rggen_access_state_e        state_q, state_d;
    logic                       write_q, write_d;
    logic [ADDRESS_WIDTH-1:0]   address_q, address_d;
    logic [DATA_WIDTH-1:0]      write_data_q, write_data_d;
    logic [DATA_WIDTH-1:0]      write_mask_q, write_mask_d;
    logic                       error_q, error_d;
    logic [DATA_WIDTH-1:0]      read_data_q, read_data_d;

    logic                       any_ready;
    logic                       decode_miss;
    logic [DATA_WIDTH-1:0]      merged_data;
    logic [DATA_WIDTH-1:0]      host_mask;
    logic                       timeout_expired;

    // Decode the register side: ready from any hit, OR-merge of all hit slices
    always_comb begin
        any_ready   = |(i_register_select & i_register_ready);
        decode_miss = ~|i_register_select;
        merged_data = '0;
        for (int n = 0; n < TOTAL_REGISTERS; n++) begin
            if (i_register_select[n]) begin
                merged_data = merged_data | i_register_read_data[n*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Expand host byte strobes to a bit mask
    always_comb begin
        host_mask = '0;
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            host_mask[b*8 +: 8] = rggen_byte_mask(i_host_strobe[b]);
        end
    end

`ifdef RGGEN_ACCESS_TIMEOUT_EN
    rggen_access_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (state_q != ACCESS),
        .i_enable  (state_q == ACCESS),
        .o_expired (timeout_expired)
    );
`else
    // Without the timer ACCESS never expires; the comparison keeps TIMEOUT_CYCLES referenced
    assign timeout_expired = (TIMEOUT_CYCLES < 0);
`endif

    // Next-state and response capture; ready beats timeout, decode miss beats both
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        address_d    = address_q;
        write_data_d = write_data_q;
        write_mask_d = write_mask_q;
        error_d      = error_q;
        read_data_d  = read_data_q;
        case (state_q)
            IDLE: begin
                if (i_host_request) begin
                    state_d      = ACCESS;
                    write_d      = i_host_write;
                    address_d    = i_host_address;
                    write_data_d = i_host_write ? i_host_write_data : '0;
                    write_mask_d = i_host_write ? host_mask : '0;
                end
            end
            ACCESS: begin
                if (decode_miss) begin
                    state_d     = RESPOND;
                    error_d     = 1'b1;
                    read_data_d = '0;
                end else if (any_ready) begin
                    state_d     = RESPOND;
                    error_d     = 1'b0;
                    read_data_d = write_q ? '0 : merged_data;
                end else if (timeout_expired) begin
                    state_d     = RESPOND;
                    error_d     = 1'b1;
                    read_data_d = '0;
                end
            end
            RESPOND: begin
                state_d     = IDLE;
                error_d     = 1'b0;
                read_data_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched command and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
            write_mask_q <= '0;
            error_q      <= 1'b0;
            read_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            write_mask_q <= write_mask_d;
            error_q      <= error_d;
            read_data_q  <= read_data_d;
        end
    end

    assign o_host_ready     = (state_q == IDLE);
    assign o_command_valid  = (state_q == ACCESS);
    assign o_host_done      = (state_q == RESPOND);
    assign o_host_error     = error_q;
    assign o_host_read_data = read_data_q;
    assign o_write          = write_q;
    assign o_address        = address_q;
    assign o_write_data     = write_data_q;
    assign o_write_mask     = write_mask_q;

endmodule

// File: doc/rggen_register_access_initiator.md
# rggen_register_access_initiator

Initiator side of the internal register command bus. Accepts one host access at a time over a valid/ready request port and drives `o_command_valid`, `o_write`, `o_address`, `o_write_data` and `o_write_mask` to every register and bit-field instance. It then waits for the selected register's ready, collects its read data and returns a one-cycle done/error response to the host. It sits between the host-bus adapter (APB/AXI front end) and the register array.

## Interface
- ADDRESS_WIDTH, 16, byte address width
- DATA_WIDTH, 32, data width; multiple of 8
- TOTAL_REGISTERS, 1, number of register instances on the bus
- TIMEOUT_CYCLES, 255, ACCESS cycles before timeout error; at least 1
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- i_host_request  input  1  host access valid
- i_host_write  input  1  1 = write, 0 = read
- i_host_address  input  ADDRESS_WIDTH  access address
- i_host_write_data  input  DATA_WIDTH  write data
- i_host_strobe  input  DATA_WIDTH/8  byte enables for writes
- o_host_ready  output  1  request accepted when high with i_host_request
- o_host_done  output  1  one-cycle response pulse
- o_host_error  output  1  error qualifier, valid with o_host_done
- o_host_read_data  output  DATA_WIDTH  read data, valid with o_host_done
- o_command_valid  output  1  command on the register bus
- o_write  output  1  latched i_host_write
- o_address  output  ADDRESS_WIDTH  latched address
- o_write_data  output  DATA_WIDTH  latched write data; 0 for reads
- o_write_mask  output  DATA_WIDTH  strobe expanded per byte to 8 bits; 0 for reads
- i_register_select  input  TOTAL_REGISTERS  per-register address hit
- i_register_ready  input  TOTAL_REGISTERS  per-register access complete
- i_register_read_data  input  TOTAL_REGISTERS*DATA_WIDTH  per-register read data; register n at slice n

## Operation
- The FSM has three states: IDLE, ACCESS and RESPOND. The reset state is IDLE.
- **IDLE:** o_host_ready=1. On i_host_request, latch write, address, data and strobe, then go to ACCESS.
- **ACCESS:** o_command_valid=1 and the latched command is held stable.
  - If no bit of i_register_select is set, report a decode error and go to RESPOND.
  - If any selected register has its ready set, capture the bitwise OR of the selected slices of read data and go to RESPOND with error=0.
  - Multiple hits are not checked; the read data is OR-merged.
- **RESPOND:** o_host_done=1 for exactly one cycle, then go to IDLE. o_host_ready=0 in this state.
- Writes and all error responses return o_host_read_data=0.
- Host request inputs are ignored outside IDLE.

## Timing
- Reset values:
  - o_host_ready=1, because it is decoded from the IDLE state.
  - o_host_done, o_host_error, o_host_read_data, o_command_valid, o_write, o_address, o_write_data and o_write_mask are all 0.
- Accept edge is T0. o_command_valid is high from T1. If ready is seen in T1, o_host_done is high in T2 and o_host_ready returns in T3. Minimum service period is 3 cycles.
- A response registered from an ACCESS cycle appears one cycle later.
- If ready and timeout occur in the same cycle, ready wins: normal completion with error=0.
- If rst_n asserts during ACCESS or RESPOND, o_command_valid and o_host_done drop immediately and the in-flight access is discarded without a response.

## Configuration
- RGGEN_ACCESS_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle.
  - When TIMEOUT_CYCLES ACCESS cycles elapse without ready, the block goes to RESPOND with error=1.
- RGGEN_ACCESS_TIMEOUT_EN undefined:
  - No counter is built.
  - ACCESS waits indefinitely for ready or for a decode miss.

## Structure
- The shared package rggen_rtl_pkg holds:
  - the state enum rggen_access_state_e (IDLE, ACCESS, RESPOND);
  - the strobe-to-mask expansion function.
- The timeout counter lives in the sub-module rggen_access_timer (clear, count enable, expired output). It is instantiated only under RGGEN_ACCESS_TIMEOUT_EN.

## Test plan
- **Write with strobe:** write to 0x04, data 0xA5A5_1234, strobe 4'b1100, reg0 selected and ready in T1 -> o_write_mask 0xFFFF_0000, o_command_valid for 1 cycle, done in T2, error 0.
- **Delayed read:** read with reg1 ready in T3, slice data 0x1234_5678 -> o_command_valid T1–T3, done T4, o_host_read_data 0x1234_5678, error 0.
- **Decode miss:** no select bits set -> done T2 with error 1 and read data 0; the next request is accepted in T3.
- **Timeout:** macro defined, TIMEOUT_CYCLES=4, selected but never ready -> 4 command cycles, then done with error 1. With the macro undefined, o_command_valid stays high for 1000 cycles with no done.
- **Ready on expiry:** ready asserted on the 4th ACCESS cycle -> done with error 0 and the captured data.
- **Reset mid-access:** rst_n low during ACCESS -> o_command_valid=0 and o_host_ready=1 immediately. After release, a read of 0x08 completes normally.
